kbd_event_log: RTL and testbench
================================

// Module: kbd_event_log
// PURPOSE
//  Parametrised keyboard-event history buffer; successor to the single 32-bit "last event" register.
//  Sits between kbd (data/done) and seven_seg (val).
//  Keeps the newest DEPTH events in a ring, counts accepted and dropped events, and shows any
//  stored event chosen by age. Supports freeze (hold the display while typing) and clear.
// PARAMETERS
//  WIDTH  32  bits per event (kbd event word)
//  DEPTH  8   ring entries; power of two, >= 2
//  CNT_W  16  width of total_cnt/drop_cnt (and rpt_cnt when enabled)
// PORTS
//  clk_100mhz  in   1                    system clock, all logic on posedge
//  rst         in   1                    asynchronous active-high reset
//  in_valid    in   1                    1-cycle event strobe (kbd done)
//  in_data     in   WIDTH                event word, sampled when in_valid=1
//  freeze      in   1                    1: incoming events dropped, ring held
//  clear       in   1                    1-cycle sync clear of ring and counters
//  view_idx    in   $clog2(DEPTH)        age select: 0=newest, DEPTH-1=oldest
//  view_data   out  WIDTH                registered selected entry (to seven_seg val)
//  view_valid  out  1                    registered; 1 when view_idx < count
//  count       out  $clog2(DEPTH+1)      stored entries, 0..DEPTH
//  total_cnt   out  CNT_W                events stored since reset/clear, saturating
//  drop_cnt    out  CNT_W                events dropped due to freeze, saturating
//  new_event   out  1                    1-cycle pulse, cycle after an event is stored
// BEHAVIOUR
//  - Reset (rst=1, async): wr_ptr=0, count=0, all counters=0, view_data=0, view_valid=0,
//    new_event=0. Ring RAM contents are don't-care; unstored entries are never visible.
//  - Store: at an edge with in_valid=1, freeze=0, clear=0:
//      mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1 (mod DEPTH);
//      count <= min(count+1, DEPTH); total_cnt += 1, saturating at 2^CNT_W-1;
//      new_event=1 for the following cycle.
//  - Full ring: the store overwrites the oldest entry; count stays DEPTH. No stall, no error.
//  - Drop: in_valid=1 with freeze=1 (and clear=0): ring, count and total_cnt unchanged;
//    drop_cnt += 1 (saturating); new_event stays 0.
//  - Clear: clear=1 sets count, wr_ptr and all counters to 0 at that edge.
//    It wins over a simultaneous in_valid: that event is neither stored nor counted as dropped.
//  - Read: every cycle, view_data <= mem[(wr_ptr-1-view_idx) mod DEPTH] when view_idx<count,
//    else 0; view_valid <= (view_idx<count).
//    Latency: an event stored at edge k is on view_data (view_idx=0) after edge k+1.
//    A view_idx change is visible after 1 edge.
//    The read uses the registered wr_ptr/count, so a same-cycle store is not bypassed.
//  - Freeze has no effect on reading; the display holds because the ring is held.
//  - No handshake back-pressure: in_valid is never refused except by freeze/clear.
//  - Reset asserted mid-operation: immediate return to reset values; any store in flight is lost.
// CONFIGURATION
//  KBD_LOG_DEDUP_EN defined:
//    - Adds output rpt_cnt [CNT_W].
//    - An otherwise storable event whose in_data equals the newest stored entry (count>0) is
//      not stored. wr_ptr, count, total_cnt and new_event are unchanged; rpt_cnt += 1 (saturating).
//    - This suppresses typematic repeat. rpt_cnt resets and clears with the other counters.
//    - Freeze and clear have priority over dedup.
//  KBD_LOG_DEDUP_EN undefined:
//    - Every accepted event is stored, duplicates included. rpt_cnt port is absent.
// TESTING
//  1. Reset, store 0x11,0x22,0x33, view_idx=0/1/2 -> 0x33/0x22/0x11, view_valid=1;
//     idx=3 -> view_data=0, view_valid=0, count=3.
//  2. Store 10 events 1..10 (DEPTH=8) -> count=8, total_cnt=10; idx 0 -> 10, idx 7 -> 3.
//  3. freeze=1, 4 strobes -> drop_cnt=4, count/total_cnt/view_data unchanged;
//     freeze=0, then 1 strobe stores normally.
//  4. clear and in_valid in the same cycle -> next cycle count=0, total_cnt=0, drop_cnt=0,
//     view_valid=0, new_event=0.
//  5. Assert rst for 1 cycle mid-stream, asynchronously between edges -> outputs zero at once;
//     the next store lands at idx 0 with count=1.
//  6. With KBD_LOG_DEDUP_EN: store 0x1C,0x1C,0x1C,0x32 -> count=2, rpt_cnt=2;
//     idx0=0x32, idx1=0x1C.

Source files
------------

// File: rtl/kbd_event_log.sv
// Keyboard event history ring: newest DEPTH events, accept/drop counters, age-indexed display read.
// Optional KBD_LOG_DEDUP_EN suppresses events equal to the newest stored entry and counts them in rpt_cnt.
module kbd_event_log #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                         clk_100mhz,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         freeze,
    input  logic                         clear,
    input  logic [$clog2(DEPTH)-1:0]     view_idx,
    output logic [WIDTH-1:0]             view_data,
    output logic                         view_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [CNT_W-1:0]             total_cnt,
    output logic [CNT_W-1:0]             drop_cnt,
`ifdef KBD_LOG_DEDUP_EN
    output logic [CNT_W-1:0]             rpt_cnt,
`endif
    output logic                         new_event
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    newest_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             accept;
    logic             is_dup;
    logic             store;
    logic             rd_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign accept     = in_valid & ~clear;
    assign newest_ptr = wr_ptr - 1'b1;
    assign rd_ptr     = newest_ptr - view_idx;
    assign rd_hit     = CW'(view_idx) < count;

`ifdef KBD_LOG_DEDUP_EN
    assign is_dup = (count != '0) && (in_data == mem[newest_ptr]);
`else
    assign is_dup = 1'b0;
`endif

    assign store = accept & ~freeze & ~is_dup;

    // Ring storage carries no reset; entries beyond count are masked on read.
    always_ff @(posedge clk_100mhz) begin
        if (store)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            count      <= '0;
            total_cnt  <= '0;
            drop_cnt   <= '0;
            view_data  <= '0;
            view_valid <= 1'b0;
            new_event  <= 1'b0;
        end else begin
            new_event  <= store;
            view_valid <= rd_hit;
            view_data  <= rd_hit ? mem[rd_ptr] : '0;
            if (clear) begin
                wr_ptr    <= '0;
                count     <= '0;
                total_cnt <= '0;
                drop_cnt  <= '0;
            end else begin
                if (store) begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    total_cnt <= sat_inc(total_cnt);
                    if (count != FULL)
                        count <= count + 1'b1;
                end
                if (accept && freeze)
                    drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

`ifdef KBD_LOG_DEDUP_EN
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst)
            rpt_cnt <= '0;
        else if (clear)
            rpt_cnt <= '0;
        else if (accept && !freeze && is_dup)
            rpt_cnt <= sat_inc(rpt_cnt);
    end
`endif

endmodule

// File: tb/tb_kbd_event_log.sv
// Randomised scoreboard bench for kbd_event_log against a queue-based history model.
// Build with KBD_LOG_DEDUP_EN defined to also exercise repeat suppression.
module tb_kbd_event_log;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk_100mhz = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              freeze = 1'b0;
    logic              clear = 1'b0;
    logic [AW-1:0]     view_idx = '0;
    logic [WIDTH-1:0]  view_data;
    logic              view_valid;
    logic [CW-1:0]     count;
    logic [CNT_W-1:0]  total_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  rpt_cnt;
    logic              new_event;

    kbd_event_log #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .freeze     (freeze),
        .clear      (clear),
        .view_idx   (view_idx),
        .view_data  (view_data),
        .view_valid (view_valid),
        .count      (count),
        .total_cnt  (total_cnt),
        .drop_cnt   (drop_cnt),
`ifdef KBD_LOG_DEDUP_EN
        .rpt_cnt    (rpt_cnt),
`endif
        .new_event  (new_event)
    );

`ifndef KBD_LOG_DEDUP_EN
    assign rpt_cnt = '0;
`endif

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct {
        logic [WIDTH-1:0] vdata;
        logic             vvalid;
        int               cnt;
        int               tot;
        int               drp;
        int               rpt;
        logic             nev;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] hist[$];
    int               m_tot = 0;
    int               m_drp = 0;
    int               m_rpt = 0;
    int               total = 0;
    int               bad = 0;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Expected outputs after the coming edge: the read reflects the history before this event.
    task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] d, input logic fz,
                                  input logic clr, input int idx);
        exp_t e;
        logic dup;
        in_valid = v;
        in_data  = d;
        freeze   = fz;
        clear    = clr;
        view_idx = AW'(idx);
        e.vvalid = idx < hist.size();
        e.vdata  = e.vvalid ? hist[idx] : '0;
        e.nev    = 1'b0;
        dup      = 1'b0;
        if (clr) begin
            hist.delete();
            m_tot = 0;
            m_drp = 0;
            m_rpt = 0;
        end else if (v && fz) begin
            m_drp = sat(m_drp);
        end else if (v) begin
`ifdef KBD_LOG_DEDUP_EN
            dup = (hist.size() > 0) && (hist[0] == d);
`endif
            if (dup) begin
                m_rpt = sat(m_rpt);
            end else begin
                hist.push_front(d);
                if (hist.size() > DEPTH)
                    void'(hist.pop_back());
                m_tot = sat(m_tot);
                e.nev = 1'b1;
            end
        end
        e.cnt = hist.size();
        e.tot = m_tot;
        e.drp = m_drp;
        e.rpt = m_rpt;
        exp_q.push_back(e);
        @(negedge clk_100mhz);
    endtask

    task automatic idle(input int idx);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, idx);
    endtask

    task automatic check_zero(input string tag);
        check_output({tag, " view_data"},  64'(view_data),  64'd0);
        check_output({tag, " view_valid"}, 64'(view_valid), 64'd0);
        check_output({tag, " count"},      64'(count),      64'd0);
        check_output({tag, " total_cnt"},  64'(total_cnt),  64'd0);
        check_output({tag, " drop_cnt"},   64'(drop_cnt),   64'd0);
        check_output({tag, " rpt_cnt"},    64'(rpt_cnt),    64'd0);
        check_output({tag, " new_event"},  64'(new_event),  64'd0);
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must drop before any edge.
    task automatic pulse_reset();
        exp_t e;
        in_valid = 1'b0;
        freeze   = 1'b0;
        clear    = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        hist.delete();
        m_tot = 0;
        m_drp = 0;
        m_rpt = 0;
        e.vdata = '0; e.vvalid = 1'b0; e.cnt = 0; e.tot = 0; e.drp = 0; e.rpt = 0; e.nev = 1'b0;
        exp_q.push_back(e);
        @(negedge clk_100mhz);
        rst = 1'b0;
    endtask

    // Monitor: one expectation is consumed per edge the driver produced one for.
    always @(posedge clk_100mhz) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("view_data",  64'(view_data),  64'(e.vdata));
            check_output("view_valid", 64'(view_valid), 64'(e.vvalid));
            check_output("count",      64'(count),      64'(e.cnt));
            check_output("total_cnt",  64'(total_cnt),  64'(e.tot));
            check_output("drop_cnt",   64'(drop_cnt),   64'(e.drp));
            check_output("rpt_cnt",    64'(rpt_cnt),    64'(e.rpt));
            check_output("new_event",  64'(new_event),  64'(e.nev));
        end
    end

    initial begin
        repeat (2) @(negedge clk_100mhz);
        check_zero("reset");
        rst = 1'b0;

        apply_stimulus(1'b1, 32'h11, 1'b0, 1'b0, 0);
        apply_stimulus(1'b1, 32'h22, 1'b0, 1'b0, 0);
        apply_stimulus(1'b1, 32'h33, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) idle(i);
        idle(3);

        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 0);
        for (int i = 1; i <= 10; i++) apply_stimulus(1'b1, WIDTH'(i), 1'b0, 1'b0, 0);
        idle(0);
        idle(7);
        idle(0);

        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 32'hA0 + WIDTH'(i), 1'b1, 1'b0, 0);
        idle(0);
        apply_stimulus(1'b1, 32'h5A, 1'b0, 1'b0, 0);
        idle(0);

        apply_stimulus(1'b1, 32'h77, 1'b0, 1'b1, 0);
        idle(0);
        idle(0);

        apply_stimulus(1'b1, 32'h41, 1'b0, 1'b0, 0);
        apply_stimulus(1'b1, 32'h42, 1'b0, 1'b0, 1);
        pulse_reset();
        apply_stimulus(1'b1, 32'h99, 1'b0, 1'b0, 0);
        idle(0);
        idle(1);

        apply_stimulus(1'b0, '0, 1'b0, 1'b1, 0);
        apply_stimulus(1'b1, 32'h1C, 1'b0, 1'b0, 0);
        apply_stimulus(1'b1, 32'h1C, 1'b0, 1'b0, 0);
        apply_stimulus(1'b1, 32'h1C, 1'b0, 1'b0, 0);
        apply_stimulus(1'b1, 32'h32, 1'b0, 1'b0, 0);
        idle(0);
        idle(1);

        // Small data alphabet provokes repeats; rare clears let counters reach saturation.
        for (int n = 0; n < 600; n++) begin
            logic v, fz, clr;
            logic [WIDTH-1:0] d;
            v   = ($urandom_range(0, 99) < 70);
            fz  = ($urandom_range(0, 99) < 20);
            clr = ($urandom_range(0, 99) < 2);
            d   = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(1, 4));
            if ($urandom_range(0, 199) == 0)
                pulse_reset();
            else
                apply_stimulus(v, d, fz, clr, int'($urandom_range(0, DEPTH-1)));
        end
        idle(0);
        @(negedge clk_100mhz);

        check_output("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
